// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one fixed-latency single-port memory.
// Port 0 is the CPU, port 1 the loader/DMA; ties alternate round-robin.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_gnt_q, last_gnt_d;
  logic          we_q, we_d;
  logic [3:0]    lat_cnt_q, lat_cnt_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          gnt1;

  // On a tie the port that did not win last time goes next.
  assign gnt1 = req1 & (~req0 | ~last_gnt_q);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_gnt_d  = last_gnt_q;
    we_d        = we_q;
    lat_cnt_d   = lat_cnt_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          sel_d       = gnt1;
          last_gnt_d  = gnt1;
          we_d        = gnt1 ? we1 : we0;
          mem_addr_d  = gnt1 ? addr1 : addr0;
          mem_wdata_d = gnt1 ? wdata1 : wdata0;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        lat_cnt_d = LAT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          if (!we_q) begin
            if (sel_q) rdata1_d = mem_rdata;
            else       rdata0_d = mem_rdata;
          end
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      we_q        <= 1'b0;
      lat_cnt_q   <= 4'd0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_gnt_q  <= last_gnt_d;
      we_q        <= we_d;
      lat_cnt_q   <= lat_cnt_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=4.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic        a_req0 = 0, a_req1 = 0, a_we0 = 0, a_we1 = 0;
  logic [31:0] a_addr0 = 0, a_addr1 = 0, a_wdata0 = 0, a_wdata1 = 0;
  logic        a_ack0, a_ack1, a_mem_en, a_mem_we;
  logic [31:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_wdata;
  logic [31:0] a_mem_rdata = 32'hBAD0BAD0;

  logic        b_req0 = 0, b_req1 = 0, b_we0 = 0, b_we1 = 0;
  logic [31:0] b_addr0 = 0, b_addr1 = 0, b_wdata0 = 0, b_wdata1 = 0;
  logic        b_ack0, b_ack1, b_mem_en, b_mem_we;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata;
  logic [31:0] b_pipe [4];

  logic [31:0] wr_addr = 0, wr_data = 0;
  int          wr_cnt = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(rst),
    .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
    .addr0(a_addr0), .addr1(a_addr1),
    .wdata0(a_wdata0), .wdata1(a_wdata1),
    .ack0(a_ack0), .ack1(a_ack1),
    .rdata0(a_rdata0), .rdata1(a_rdata1),
    .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) dut_b (
    .clk(clk), .reset(rst),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1),
    .wdata0(b_wdata0), .wdata1(b_wdata1),
    .ack0(b_ack0), .ack1(b_ack1),
    .rdata0(b_rdata0), .rdata1(b_rdata1),
    .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_pipe[3])
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    case (a)
      32'h40:  mdata = 32'hDEADBEEF;
      32'h44:  mdata = 32'h11223344;
      32'h48:  mdata = 32'h55667788;
      32'h4C:  mdata = 32'h99AABBCC;
      32'h08:  mdata = 32'hCAFEF00D;
      default: mdata = 32'h0;
    endcase
  endfunction

  // Read data is valid only exactly MEM_LAT cycles after the mem_en cycle.
  always @(posedge clk) begin
    a_mem_rdata <= (a_mem_en && !a_mem_we) ? mdata(a_mem_addr) : 32'hBAD0BAD0;
    b_pipe[0]   <= (b_mem_en && !b_mem_we) ? mdata(b_mem_addr) : 32'hBAD0BAD0;
    b_pipe[1]   <= b_pipe[0];
    b_pipe[2]   <= b_pipe[1];
    b_pipe[3]   <= b_pipe[2];
    if (a_mem_en && a_mem_we) begin
      wr_addr <= a_mem_addr;
      wr_data <= a_mem_wdata;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_ack0", 32'(a_ack0), 0);
    chk("rst_ack1", 32'(a_ack1), 0);
    chk("rst_mem_en", 32'(a_mem_en), 0);
    chk("rst_mem_we", 32'(a_mem_we), 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_mem_wdata", a_mem_wdata, 0);
    chk("rst_rdata0", a_rdata0, 0);
    chk("rst_rdata1", a_rdata1, 0);
    chk("rst_b_mem_en", 32'(b_mem_en), 0);
    rst = 1'b0;
    tick();
    chk("idle_no_en", 32'(a_mem_en), 0);

    // Single read, MEM_LAT=1
    a_req0 = 1; a_we0 = 0; a_addr0 = 32'h40;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("rd_mem_en_c%0d", i), 32'(a_mem_en), 32'(i == 1));
      chk($sformatf("rd_ack0_c%0d", i), 32'(a_ack0), 32'(i == 3));
      chk($sformatf("rd_ack1_c%0d", i), 32'(a_ack1), 0);
      if (i == 1) begin
        chk("rd_mem_addr", a_mem_addr, 32'h40);
        chk("rd_mem_we", 32'(a_mem_we), 0);
      end
      if (i == 3) begin
        chk("rd_rdata0", a_rdata0, 32'hDEADBEEF);
        a_req0 = 0;
      end
    end

    // Write on port 1
    a_req1 = 1; a_we1 = 1; a_addr1 = 32'h10; a_wdata1 = 32'h12345678;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("wr_mem_en_c%0d", i), 32'(a_mem_en), 32'(i == 1));
      chk($sformatf("wr_mem_we_c%0d", i), 32'(a_mem_we), 32'(i == 1));
      chk($sformatf("wr_ack1_c%0d", i), 32'(a_ack1), 32'(i == 3));
      chk($sformatf("wr_ack0_c%0d", i), 32'(a_ack0), 0);
      if (i == 1) begin
        chk("wr_mem_addr", a_mem_addr, 32'h10);
        chk("wr_mem_wdata", a_mem_wdata, 32'h12345678);
      end
      if (i == 3) begin
        chk("wr_rdata1_kept", a_rdata1, 0);
        chk("wr_rdata0_kept", a_rdata0, 32'hDEADBEEF);
        a_req1 = 0; a_we1 = 0;
      end
    end
    chk("wr_count", 32'(wr_cnt), 1);
    chk("wr_seen_addr", wr_addr, 32'h10);
    chk("wr_seen_data", wr_data, 32'h12345678);

    // Contention right after reset: order 0,1,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_req0 = 1; a_we0 = 0; a_addr0 = 32'h44;
    a_req1 = 1; a_we1 = 0; a_addr1 = 32'h48;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("ct_mem_en_c%0d", i), 32'(a_mem_en),
          32'(i == 1 || i == 5 || i == 9));
      chk($sformatf("ct_ack0_c%0d", i), 32'(a_ack0), 32'(i == 3 || i == 11));
      chk($sformatf("ct_ack1_c%0d", i), 32'(a_ack1), 32'(i == 7));
      if (i == 1 || i == 9) chk($sformatf("ct_addr_c%0d", i), a_mem_addr, 32'h44);
      if (i == 5) chk("ct_addr_c5", a_mem_addr, 32'h48);
      if (i == 3) chk("ct_rdata0", a_rdata0, 32'h11223344);
      if (i == 7) chk("ct_rdata1", a_rdata1, 32'h55667788);
      if (i == 11) begin
        a_req0 = 0;
        a_req1 = 0;
      end
    end

    // Latency parameter, MEM_LAT=4
    b_req0 = 1; b_we0 = 0; b_addr0 = 32'h08;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("lat_mem_en_c%0d", i), 32'(b_mem_en), 32'(i == 1));
      chk($sformatf("lat_ack0_c%0d", i), 32'(b_ack0), 32'(i == 6));
      chk($sformatf("lat_rdata0_c%0d", i), b_rdata0,
          (i >= 6) ? 32'hCAFEF00D : 32'h0);
      if (i == 1) chk("lat_mem_addr", b_mem_addr, 32'h08);
      if (i == 6) b_req0 = 0;
    end

    // Reset during WAIT
    a_req0 = 1; a_we0 = 0; a_addr0 = 32'h40;
    tick();
    chk("ab_mem_en", 32'(a_mem_en), 1);
    tick();
    #2;
    rst = 1'b1;
    a_req0 = 0;
    #1;
    chk("ab_async_mem_addr", a_mem_addr, 0);
    chk("ab_async_rdata0", a_rdata0, 0);
    chk("ab_async_rdata1", a_rdata1, 0);
    chk("ab_async_ack0", 32'(a_ack0), 0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("ab_no_ack0_c%0d", i), 32'(a_ack0), 0);
      chk($sformatf("ab_no_en_c%0d", i), 32'(a_mem_en), 0);
    end
    a_req0 = 1; a_addr0 = 32'h44;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("ab_fresh_ack0_c%0d", i), 32'(a_ack0), 32'(i == 3));
      if (i == 3) begin
        chk("ab_fresh_rdata0", a_rdata0, 32'h11223344);
        a_req0 = 0;
      end
    end

    // Request arriving while port 0 is busy
    a_req0 = 1; a_we0 = 0; a_addr0 = 32'h48;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) begin
        a_req1 = 1; a_we1 = 0; a_addr1 = 32'h4C;
      end
      chk($sformatf("bz_mem_en_c%0d", i), 32'(a_mem_en), 32'(i == 1 || i == 5));
      chk($sformatf("bz_ack0_c%0d", i), 32'(a_ack0), 32'(i == 3));
      chk($sformatf("bz_ack1_c%0d", i), 32'(a_ack1), 32'(i == 7));
      if (i == 3) begin
        chk("bz_rdata0", a_rdata0, 32'h55667788);
        a_req0 = 0;
      end
      if (i == 5) chk("bz_mem_addr", a_mem_addr, 32'h4C);
      if (i == 7) begin
        chk("bz_rdata1", a_rdata1, 32'h99AABBCC);
        a_req1 = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
